// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, even parity, stop bit.
// Bit period is 16 oversample ticks, matching the receiver's timing arithmetic.
module uart_tx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  TxD,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int CYCLES_PER_TICK = CLK_FREQ / (BAUD_RATE * 16);
  localparam int CYCLES_PER_BIT  = CYCLES_PER_TICK * 16;
  localparam int BCW             = $clog2(CYCLES_PER_BIT);
  localparam int DCW             = $clog2(DATA_WIDTH) + 1;
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(CYCLES_PER_BIT - 1);
  localparam logic [DCW-1:0] DATA_LAST = DCW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state;
  logic [BCW-1:0]        bit_cnt;
  logic [DCW-1:0]        data_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  parity;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      data_cnt <= '0;
      shreg    <= '0;
      parity   <= 1'b0;
      TxD      <= 1'b1;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          bit_cnt  <= '0;
          data_cnt <= '0;
          if (tx_valid) begin
            shreg    <= tx_data;
            parity   <= ^tx_data;
            TxD      <= 1'b0;
            state    <= START;
            busy     <= 1'b1;
            tx_ready <= 1'b0;
          end
        end
        default: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            // Each bit boundary decides what TxD carries for the next period.
            case (state)
              START: begin
                TxD   <= shreg[0];
                shreg <= shreg >> 1;
                state <= DATA;
              end
              DATA: begin
                if (data_cnt == DATA_LAST) begin
                  data_cnt <= '0;
                  TxD      <= parity;
                  state    <= PARITY;
                end else begin
                  data_cnt <= data_cnt + DCW'(1);
                  TxD      <= shreg[0];
                  shreg    <= shreg >> 1;
                end
              end
              PARITY: begin
                TxD   <= 1'b1;
                state <= STOP;
              end
              STOP: begin
                state    <= IDLE;
                tx_done  <= 1'b1;
                busy     <= 1'b0;
                tx_ready <= 1'b1;
              end
              default: state <= IDLE;
            endcase
          end else begin
            bit_cnt <= bit_cnt + BCW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 16 cycles per bit (176-cycle frames).
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, TxD, busy, tx_done;

  int checks = 0;
  int passed = 0;

  uart_tx #(
    .CLK_FREQ  (1_600_000),
    .BAUD_RATE (100_000),
    .DATA_WIDTH(8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .TxD     (TxD),
    .busy    (busy),
    .tx_done (tx_done)
  );

  always #5 clk = ~clk;

  // Handshake one word, then sample each bit at its centre; bits = {stop, parity, data, start}.
  task automatic run_frame(input logic [7:0] d, input int chg_at, input logic [7:0] chg_val,
                           output logic [10:0] bits, output int done_i, output int ndone);
    bits = '0;
    done_i = -1;
    ndone = 0;
    @(posedge clk); #1;
    tx_data = d;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    for (int i = 0; i < 190; i++) begin
      @(negedge clk);
      if (i % 16 == 8 && i < 176) bits[i/16] = TxD;
      if (tx_done === 1'b1) begin
        ndone++;
        if (done_i < 0) done_i = i;
      end
      if (i == chg_at) tx_data = chg_val;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2 reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({TxD, tx_ready, busy, tx_done} !== 4'b1100)
        $display("FAIL reset_hold: {TxD,ready,busy,done}=%b expected 1100", {TxD, tx_ready, busy, tx_done});
      else passed++;
    end
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({TxD, tx_ready, busy, tx_done} !== 4'b1100)
        $display("FAIL reset_release: {TxD,ready,busy,done}=%b expected 1100", {TxD, tx_ready, busy, tx_done});
      else passed++;
    end
  endtask

  task automatic test_frame_a5();
    logic [10:0] bits;
    int di, nd;
    run_frame(8'hA5, -1, 8'h00, bits, di, nd);
    checks++;
    if (bits !== 11'h54A) $display("FAIL a5_bits: got %h expected 54a", bits);
    else passed++;
    checks++;
    if (di !== 176) $display("FAIL a5_done_time: got %0d expected 176", di);
    else passed++;
    checks++;
    if (nd !== 1) $display("FAIL a5_done_count: got %0d expected 1", nd);
    else passed++;
  endtask

  task automatic test_parity_and_hold();
    logic [10:0] bits;
    int di, nd;
    run_frame(8'h07, 40, 8'hFF, bits, di, nd);
    checks++;
    if (bits !== 11'h60E) $display("FAIL p07_bits: got %h expected 60e", bits);
    else passed++;
    checks++;
    if (di !== 176) $display("FAIL p07_done_time: got %0d expected 176", di);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [10:0] b1, b2;
    int rdy_cnt, fall_i, nd, d2;
    logic prev;
    b1 = '0; b2 = '0;
    rdy_cnt = 0; fall_i = -1; nd = 0; d2 = -1;
    prev = 1'b0;
    @(posedge clk); #1;
    tx_data = 8'h00;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_data = 8'hFF;
    for (int i = 0; i < 370; i++) begin
      @(negedge clk);
      if (i < 176 && i % 16 == 8) b1[i/16] = TxD;
      if (i >= 177 && i < 353 && (i - 177) % 16 == 8) b2[(i-177)/16] = TxD;
      if (i <= 200 && tx_ready === 1'b1) rdy_cnt++;
      if (prev === 1'b1 && TxD === 1'b0 && fall_i < 0) fall_i = i;
      prev = TxD;
      if (tx_done === 1'b1) begin
        nd++;
        if (i > 176) d2 = i;
      end
      if (i == 180) tx_valid = 1'b0;
    end
    checks++;
    if (b1 !== 11'h400) $display("FAIL b2b_first_bits: got %h expected 400", b1);
    else passed++;
    checks++;
    if (b2 !== 11'h5FE) $display("FAIL b2b_second_bits: got %h expected 5fe", b2);
    else passed++;
    checks++;
    if (fall_i !== 177) $display("FAIL b2b_start_spacing: got %0d expected 177", fall_i);
    else passed++;
    checks++;
    if (rdy_cnt !== 1) $display("FAIL b2b_ready_cycles: got %0d expected 1", rdy_cnt);
    else passed++;
    checks++;
    if (nd !== 2 || d2 !== 353) $display("FAIL b2b_done: count %0d at %0d expected 2 at 353", nd, d2);
    else passed++;
  endtask

  task automatic test_reset_midframe();
    logic [10:0] bits;
    int di, nd, aborted_done;
    @(posedge clk); #1;
    tx_data = 8'h3C;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    for (int i = 0; i <= 70; i++) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({TxD, tx_ready, busy, tx_done} !== 4'b1100)
      $display("FAIL midframe_reset_async: {TxD,ready,busy,done}=%b expected 1100", {TxD, tx_ready, busy, tx_done});
    else passed++;
    aborted_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (tx_done === 1'b1) aborted_done++;
    end
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (tx_done === 1'b1) aborted_done++;
    end
    checks++;
    if (aborted_done !== 0) $display("FAIL midframe_no_done: got %0d pulses expected 0", aborted_done);
    else passed++;
    run_frame(8'h81, -1, 8'h00, bits, di, nd);
    checks++;
    if (bits !== 11'h502) $display("FAIL post_reset_bits: got %h expected 502", bits);
    else passed++;
    checks++;
    if (di !== 176 || nd !== 1) $display("FAIL post_reset_done: count %0d at %0d expected 1 at 176", nd, di);
    else passed++;
  endtask

  task automatic test_loopback();
    logic [10:0] bits;
    logic [7:0]  rx;
    int di, nd;
    for (int w = 0; w < 256; w++) begin
      run_frame(8'(w), -1, 8'h00, bits, di, nd);
      rx = bits[8:1];
      checks++;
      if (rx !== 8'(w)) $display("FAIL loop_data: got %h expected %h", rx, 8'(w));
      else passed++;
      // Receiver-side framing: start low, stop high, parity makes the ones count even.
      checks++;
      if ({bits[10], bits[9] ^ (^rx), bits[0]} !== 3'b100)
        $display("FAIL loop_frame: word %h stop/parity_err/start=%b expected 100", 8'(w),
                 {bits[10], bits[9] ^ (^rx), bits[0]});
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_parity_and_hold();
    test_back_to_back();
    test_reset_midframe();
    test_loopback();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Transmit half of the UART link. Serialises parallel words onto the TxD line for the UART receiver to recover.
- Frame format: one start bit (0), DATA_WIDTH data bits LSB first, one even-parity bit, one stop bit (1).
- Bit timing uses the receiver's 16x oversample arithmetic, so both ends agree on an identical bit period.
- Sits between the host-side producer (valid/ready) and the serial line.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD_RATE, 115_200: line rate in bits/s.
- DATA_WIDTH, 8: data bits per frame, minimum 5.
- Derived, not overridable:
  - CYCLES_PER_TICK = CLK_FREQ / (BAUD_RATE*16), integer division, must be ≥1.
  - CYCLES_PER_BIT = CYCLES_PER_TICK*16. Defaults give 27*16 = 432.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- tx_data  in  DATA_WIDTH  word to send; sampled only on handshake.
- tx_valid  in  1  producer has a word on tx_data.
- tx_ready  out  1  block can accept a word.
- TxD  out  1  serial line; idles high.
- busy  out  1  frame in progress.
- tx_done  out  1  one-cycle pulse at the end of the stop bit.

Behaviour:
- Reset (reset=0), applied immediately without waiting for a clock edge:
  - TxD=1, tx_ready=1, busy=0, tx_done=0.
  - State IDLE; all counters and the shift register cleared.
- All outputs are registered. TxD has no combinational path from any input.
- State machine: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
- IDLE:
  - tx_ready=1, busy=0, TxD=1.
  - On the edge where tx_valid=1 (handshake), latch tx_data into the shift register and latch parity = XOR of tx_data.
  - On that same edge: TxD<=0, state<=START, busy<=1, tx_ready<=0.
- START, DATA, PARITY, STOP each hold TxD stable for exactly CYCLES_PER_BIT cycles.
  - A bit counter runs 0..CYCLES_PER_BIT-1; the terminal count advances to the next bit.
- DATA:
  - Drive shift register bit 0, then shift right at each bit boundary.
  - A data-bit counter of width $clog2(DATA_WIDTH)+1 leaves DATA after exactly DATA_WIDTH bits.
- PARITY: TxD = latched even parity, so the data bits plus the parity bit contain an even number of ones.
- STOP:
  - TxD=1.
  - At the terminal count: state<=IDLE, tx_done<=1 for one cycle, busy<=0, tx_ready<=1.
- Frame length, handshake edge to tx_done edge: (DATA_WIDTH+3)*CYCLES_PER_BIT cycles.
- Back-to-back traffic: with tx_valid held high, the next handshake occurs on the first IDLE cycle after tx_done.
  - The stop bit is therefore CYCLES_PER_BIT+1 cycles.
  - Consecutive start edges are (DATA_WIDTH+3)*CYCLES_PER_BIT+1 cycles apart.
- Holding and ignoring inputs:
  - tx_valid while busy is ignored, and nothing is queued; the producer must hold tx_valid until tx_ready.
  - Changes to tx_data after the handshake do not affect the frame in flight.
- Reset mid-frame: the frame is aborted, TxD returns to 1 asynchronously, and no tx_done is issued. The first handshake after reset release starts a clean frame.
- Counter wrap: all counters reset to 0 at their terminal counts. No counter may overflow at any legal parameter set.

Test Plan:
Test benches use CLK_FREQ=1_600_000 and BAUD_RATE=100_000, giving CYCLES_PER_BIT=16 and an 11-bit frame of 176 cycles.
1. Hold reset=0 for 5 cycles, then release -> TxD=1, tx_ready=1, busy=0, tx_done=0 throughout and after release, with no activity.
2. Send 0xA5 with a single-cycle tx_valid -> TxD sequence (16 cycles each) is 0, 1,0,1,0,0,1,0,1, parity 0, stop 1. tx_done pulses once, 176 cycles after the handshake edge.
3. Send 0x07 -> parity bit 1 (three ones). Change tx_data to 0xFF mid-DATA -> the remaining data bits are still those of 0x07.
4. Hold tx_valid=1 with 0x00 then 0xFF -> both frames have parity 0. Second start falling edge is exactly 177 cycles after the first. tx_ready is high for exactly one cycle between frames.
5. Assert reset during data bit 3 of 0x3C -> TxD=1 before the next clock edge, no tx_done. After release, 0x81 is sent correctly.
6. Loopback TxD into the UART receiver with matching parameters, 256 words 0x00..0xFF -> every received word equals the sent word, with parity match reported on every frame.
